// File: rtl/ghist_pkg.sv
// Shared types and constants for the global-history SRAM client port.
// Contents: geometry of the ghist_40x72 macro, index/word typedefs and the
// response payload carried through the read response buffer.
package ghist_pkg;

  localparam int unsigned GHIST_DEPTH = 40;
  localparam int unsigned GHIST_WIDTH = 72;
  localparam int unsigned GHIST_AW    = 6;

  typedef logic [GHIST_WIDTH-1:0] ghist_word_t;
  typedef logic [GHIST_AW-1:0]    ghist_idx_t;

  // One read response: data word plus out-of-range flag.
  typedef struct packed {
    ghist_word_t data;
    logic        err;
  } ghist_resp_t;

endpackage

// File: rtl/ghist_resp_skid.sv
// Two-entry ordered response buffer for ghist_mem_port.
// Ports:
//   clock, reset  : clock and synchronous active-high reset (empties the buffer)
//   push_i        : enqueue push_data_i (caller guarantees a free slot or a same-cycle pop)
//   push_data_i   : response to enqueue
//   pop_i         : dequeue the head; ignored when empty
//   head_o        : oldest entry
//   valid_o       : buffer non-empty
//   count_o       : occupancy 0..2
module ghist_resp_skid
  import ghist_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  ghist_resp_t push_data_i,
  input  logic        pop_i,
  output ghist_resp_t head_o,
  output logic        valid_o,
  output logic [1:0]  count_o
);

  ghist_resp_t entry_q [2];
  ghist_resp_t entry_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        pop_ok;

  // Pointer/occupancy update; push into the slot being popped is fine because
  // the head is read from the current-state register.
  always_comb begin
    pop_ok   = pop_i & (count_q != 2'd0);
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      entry_d[wr_ptr_q] = push_data_i;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push_i) - 2'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/ghist_mem_port.sv
// Client-side controller for the ghist_40x72 global-history SRAM macro.
// Converts valid/ready read and write requests into R0/W0 macro activity,
// absorbs the one-cycle macro read latency with a 2-entry response buffer,
// range-checks indices (>= DEPTH is out of range).
// Optional feature: define GHIST_MEM_PORT_BYPASS_EN to forward accepted
// writes from the issue cycle and the capture cycle into colliding reads.
// Ports:
//   clock, reset                   : clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data : write request channel
//   wr_err                         : pulse, previous accepted write was out of range
//   rd_req_valid/rd_req_ready/rd_req_addr : read request channel
//   rd_resp_valid/rd_resp_ready/rd_resp_data/rd_resp_err : read response channel
//   R0_addr/R0_en/R0_data          : macro read port (data one cycle after enable)
//   W0_addr/W0_en/W0_data          : macro write port
module ghist_mem_port
  import ghist_pkg::*;
#(
  parameter int unsigned DEPTH = GHIST_DEPTH,
  parameter int unsigned WIDTH = GHIST_WIDTH,
  parameter int unsigned AW    = GHIST_AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [AW-1:0]    rd_req_addr,
  output logic             rd_resp_valid,
  input  logic             rd_resp_ready,
  output logic [WIDTH-1:0] rd_resp_data,
  output logic             rd_resp_err,
  output logic             wr_err,
  output logic [AW-1:0]    R0_addr,
  output logic             R0_en,
  input  logic [WIDTH-1:0] R0_data,
  output logic [AW-1:0]    W0_addr,
  output logic             W0_en,
  output logic [WIDTH-1:0] W0_data
);

  logic        wr_fire, wr_inrange;
  logic        rd_fire, rd_inrange;
  logic        resp_pop;
  logic [2:0]  occ;
  logic        wr_err_q;
  logic        inflight_q;
  logic        infl_err_q;
  ghist_resp_t cap_resp;
  ghist_resp_t skid_head;
  logic        skid_valid;
  logic [1:0]  skid_count;
  ghist_word_t cap_data;

  // Write path: accepted whenever out of reset, zero added latency.
  assign wr_ready   = ~reset;
  assign wr_fire    = wr_valid & wr_ready;
  assign wr_inrange = (32'(wr_addr) < DEPTH);
  assign W0_en      = wr_fire & wr_inrange;
  assign W0_addr    = W0_en ? wr_addr : '0;
  assign W0_data    = W0_en ? wr_data : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_fire & ~wr_inrange;
    end
  end

  assign wr_err = wr_err_q & ~reset;

  // Credit: in-flight flag plus buffer occupancy; a slot freed by this
  // cycle's pop is reusable immediately so reads stream one per cycle.
  assign resp_pop     = rd_resp_valid & rd_resp_ready;
  assign occ          = 3'(inflight_q) + 3'(skid_count);
  assign rd_req_ready = ~reset & ((occ - 3'(resp_pop)) < 3'd2);

  // Read issue: out-of-range reads consume a slot but never touch the macro.
  assign rd_fire    = rd_req_valid & rd_req_ready;
  assign rd_inrange = (32'(rd_req_addr) < DEPTH);
  assign R0_en      = rd_fire & rd_inrange;
  assign R0_addr    = R0_en ? rd_req_addr : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
      infl_err_q <= 1'b0;
    end else begin
      inflight_q <= rd_fire;
      infl_err_q <= rd_fire & ~rd_inrange;
    end
  end

`ifdef GHIST_MEM_PORT_BYPASS_EN
  logic [AW-1:0]    infl_addr_q;
  logic             prev_wr_en_q;
  logic [AW-1:0]    prev_wr_addr_q;
  logic [WIDTH-1:0] prev_wr_data_q;

  // Remember the issued read index and the issue-cycle write for forwarding.
  always_ff @(posedge clock) begin
    if (reset) begin
      infl_addr_q    <= '0;
      prev_wr_en_q   <= 1'b0;
      prev_wr_addr_q <= '0;
      prev_wr_data_q <= '0;
    end else begin
      infl_addr_q    <= rd_req_addr;
      prev_wr_en_q   <= W0_en;
      prev_wr_addr_q <= W0_addr;
      prev_wr_data_q <= W0_data;
    end
  end

  // Capture-cycle write wins over the issue-cycle write, which wins over the macro.
  always_comb begin
    cap_data = GHIST_WIDTH'(R0_data);
    if (infl_err_q) begin
      cap_data = '0;
    end else if (W0_en && (W0_addr == infl_addr_q)) begin
      cap_data = GHIST_WIDTH'(W0_data);
    end else if (prev_wr_en_q && (prev_wr_addr_q == infl_addr_q)) begin
      cap_data = GHIST_WIDTH'(prev_wr_data_q);
    end
  end
`else
  // Capture raw macro data; out-of-range reads return zero.
  always_comb begin
    cap_data = GHIST_WIDTH'(R0_data);
    if (infl_err_q) begin
      cap_data = '0;
    end
  end
`endif

  always_comb begin
    cap_resp      = '0;
    cap_resp.data = cap_data;
    cap_resp.err  = infl_err_q;
  end

  ghist_resp_skid u_skid (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inflight_q & ~reset),
    .push_data_i (cap_resp),
    .pop_i       (resp_pop),
    .head_o      (skid_head),
    .valid_o     (skid_valid),
    .count_o     (skid_count)
  );

  // Response outputs read zero while idle or in reset.
  assign rd_resp_valid = skid_valid & ~reset;
  assign rd_resp_data  = rd_resp_valid ? WIDTH'(skid_head.data) : '0;
  assign rd_resp_err   = rd_resp_valid & skid_head.err;

endmodule
